uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  UART 8N1 transmitter with an integrated byte FIFO; the outbound counterpart of the board rx path.
//  Logic writes bytes (switch snapshots, replies, ASCII text) without waiting on the line.
//  The block serialises the queued bytes back-to-back on tx, LSB first.
//  Sits between user logic and the board UART tx pin; one clock domain.
// PARAMETERS
//  CLK_FREQ    100000000  system clock frequency, Hz
//  BAUD        115200     line rate, bit/s; DIV = CLK_FREQ/BAUD (integer divide), DIV >= 2 required
//  FIFO_DEPTH  16         FIFO entries; power of two, >= 2
//  AW          4          log2(FIFO_DEPTH)
// PORTS
//  clk       in   1     system clock, all logic on posedge
//  rst       in   1     synchronous reset, active-low (0 = reset)
//  wr_en     in   1     push wr_data into FIFO this cycle
//  wr_data   in   8     byte to queue
//  full      out  1     FIFO holds FIFO_DEPTH entries
//  empty     out  1     FIFO holds 0 entries
//  level     out  AW+1  current FIFO occupancy, 0..FIFO_DEPTH
//  overflow  out  1     sticky: a write was dropped because FIFO was full
//  busy      out  1     serialiser mid-frame (state != IDLE)
//  tx        out  1     serial line, idle high, registered
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - tx=1, busy=0, empty=1, full=0, level=0, overflow=0.
//   - Pointers cleared; any frame in flight is aborted, so tx is 1 from the next cycle.
//  FIFO:
//   - Write accepted iff wr_en && !full (full as registered at that edge).
//   - Write while full: dropped, FIFO unchanged, overflow<=1; overflow held until reset.
//   - Write and pop in the same cycle: level unchanged; both take effect.
//   - A write on a full cycle is dropped even if a pop occurs in the same cycle.
//   - Pointers wrap modulo FIFO_DEPTH. full/empty/level are registered and updated the cycle after the event.
//  FSM states: IDLE, START, DATA, STOP. Baud counter bcnt runs 0..DIV-1; bit index bidx runs 0..7.
//   - IDLE:  tx=1. If !empty: pop head into shift reg, bcnt=0, go to START.
//   - START: tx=0 for DIV cycles, then go to DATA with bidx=0.
//   - DATA:  tx=shift[bidx] for DIV cycles each; after bidx 7 go to STOP.
//   - STOP:  tx=1 for DIV cycles. At the end: if !empty, pop and go straight to START (no idle gap); else go to IDLE.
//  Latency and frame:
//   - Write at edge N to an empty FIFO with FSM idle: empty=0 after N, pop at N+1, tx=0 from edge N+2.
//   - Frame length is exactly 10*DIV cycles; busy=1 for the whole frame.
//  Data handling:
//   - wr_data is taken verbatim; 0x0A and 0x00 have no special meaning.
//   - Bytes leave in write order; no byte is duplicated or lost except writes dropped while full.
// TESTING (CLK_FREQ=1600, BAUD=100 -> DIV=16, FIFO_DEPTH=4, AW=2)
//  1. Reset, idle 50 cycles -> tx=1, busy=0, empty=1, level=0 throughout.
//  2. Write 0x55 once:
//     -> tx=0 from 2nd edge after write, then bits 1,0,1,0,1,0,1,0, then stop 1, each 16 cycles.
//     -> busy falls 160 cycles after the start bit begins.
//  3. Write 0xA3,0x0A,0x00 on consecutive cycles:
//     -> three frames back-to-back with no idle gap, data decoded in that order, 480 cycles total.
//  4. With FSM blocked mid-frame, write 6 bytes 0x01..0x06:
//     -> one byte is popped at the first write, so bytes 0x01..0x05 are accepted.
//     -> full=1, level=4, overflow=1, and 0x06 is never transmitted.
//  5. With full=1, assert wr_en on the cycle the FSM pops:
//     -> the write is dropped, level drops to 3, overflow=1.
//  6. Assert rst=0 during bit 4 of a frame with 2 bytes queued:
//     -> tx=1 next cycle, level=0, and no further frames until new writes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO; a write to an idle, empty block starts the start bit two edges later.
// No backpressure: writes while full are dropped and flagged on the sticky overflow output.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          busy,
  output logic          tx
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(DIV - 1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic push;
  logic pop;

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    bidx_d     = bidx_q;
    shift_d    = shift_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    pop        = 1'b0;
    push       = wr_en && !full_q;

    unique case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          bcnt_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d  = '0;
          bidx_d  = '0;
          state_d = DATA;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d = '0;
          if (bidx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d = '0;
          // Chain straight into the next frame when data is waiting.
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (wr_en && full_q) begin
      overflow_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);

    // tx and busy are registered copies of the current state, so both lag state by one edge.
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[bidx_q];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      bidx_q     <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      bidx_q     <= bidx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo: a queue-and-frame-timer reference model predicts the
// per-cycle status and line level, while a line decoder checks each received byte against the queue.
module tb_uart_tx_fifo;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, busy, tx;
  logic [2:0] level;

  uart_tx_fifo #(
    .CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(DEPTH), .AW(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; a frame is a countdown of FRAME cycles started at each pop.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic [7:0] m_cur = 8'h00;
  int         m_t = 0;
  logic       m_ovf = 1'b0, m_busy = 1'b0, m_tx = 1'b1;
  int         epoch = 0;
  bit         chk_en = 1'b0;

  function automatic logic line_bit(input logic [7:0] b, input int pos);
    int k;
    k = pos / DIV;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  always @(posedge clk) begin
    bit pop_ok, accept;
    if (!rst) begin
      mq.delete();
      sb.delete();
      m_t    = 0;
      m_ovf  = 1'b0;
      m_busy = 1'b0;
      m_tx   = 1'b1;
      epoch++;
      chk_en = 1'b1;
    end else begin
      m_busy = (m_t > 0);
      m_tx   = (m_t > 0) ? line_bit(m_cur, FRAME - m_t) : 1'b1;
      pop_ok = (m_t <= 1);
      if (m_t > 0) m_t--;
      accept = wr_en && (mq.size() < DEPTH);
      if (wr_en && !accept) m_ovf = 1'b1;
      if (pop_ok && mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_t   = FRAME;
      end
      if (accept) begin
        mq.push_back(wr_data);
        sb.push_back(wr_data);
      end
    end
  end

  // Monitor: per-cycle status check plus a mid-bit line decoder that pops the scoreboard per frame.
  bit         dec_active = 1'b0;
  int         dec_cnt = 0;
  int         dec_epoch = 0;
  logic [7:0] dec_byte = 8'h00;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 32'(level), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("tx", 32'(tx), 32'(m_tx));

      if (dec_epoch != epoch) begin
        dec_epoch  = epoch;
        dec_active = 1'b0;
      end
      if (!dec_active && tx === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
      if (dec_active) begin
        if (dec_cnt >= DIV + DIV/2 && dec_cnt < 9*DIV && (dec_cnt % DIV) == DIV/2)
          dec_byte[dec_cnt/DIV - 1] = tx;
        if (dec_cnt == 9*DIV + DIV/2) begin
          dec_active = 1'b0;
          chk("stop_bit", 32'(tx), 32'd1);
          if (sb.size() == 0) begin
            chk("unexpected_frame", 32'(dec_byte), 32'hFFFF_FFFF);
          end else begin
            chk("frame_data", 32'(dec_byte), 32'(sb.pop_front()));
          end
        end
        dec_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_t(input int target, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (m_t == target) break;
      tick();
    end
    if (i == limit) chk("wait_timeout", 32'(m_t), 32'(target));
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (m_t == 0 && mq.size() == 0) break;
      tick();
    end
    if (i == limit) chk("idle_timeout", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) tick();
    rst = 1'b1;

    // Idle line after reset.
    repeat (50) tick();

    // Single byte, then a back-to-back burst including 0x0A and 0x00.
    wr(8'h55);
    wait_idle(400);
    repeat (5) tick();
    wr(8'hA3);
    wr(8'h0A);
    wr(8'h00);
    wait_idle(800);
    repeat (5) tick();

    // Overfill while the serialiser is busy; 0x06 must be dropped.
    for (int b = 1; b <= 6; b++) wr(8'(b));
    // Write on the exact pop cycle while full: still dropped.
    wait_t(1, 400);
    wr(8'h77);
    wait_idle(1500);
    repeat (5) tick();

    // Reset during data bit 4 with two bytes still queued.
    wr(8'hC4);
    wr(8'h5B);
    wr(8'h9E);
    wait_t(FRAME - 85, 400);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (50) tick();

    // Random traffic with alternating light/heavy load and rare resets.
    for (int c = 0; c < 4000; c++) begin
      if (((c / 500) % 2) == 1) wr_en = ($urandom_range(0, 1) == 0);
      else                      wr_en = ($urandom_range(0, 11) == 0);
      wr_data = 8'($urandom);
      rst     = ($urandom_range(0, 1499) != 0);
      tick();
    end
    wr_en = 1'b0;
    rst   = 1'b1;
    wait_idle(3000);
    repeat (20) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
